// File: rtl/timer_display_scan_pkg.sv
// rtl/timer_display_scan_pkg.sv - shared timer display constants and scan state encoding
package timer_display_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_DASH  = 7'b0111111;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    // Entry k is the pattern for BCD digit k (entry 9 is the leftmost element)
    localparam logic [9:0][6:0] SEG7_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/timer_display_scan_if.sv
// rtl/timer_display_scan_if.sv - digit source and display pin bundle for the scan driver
interface timer_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    frame_start;

    modport master (
        output digits_in, dp_mask, blank_lz, blink_en,
        input  an_n, seg_n, dp_n, frame_start
    );

    modport slave (
        input  digits_in, dp_mask, blank_lz, blink_en,
        output an_n, seg_n, dp_n, frame_start
    );
endinterface

// File: rtl/timer_display_scan_bcd_to_seg7.sv
// rtl/timer_display_scan_bcd_to_seg7.sv - combinational BCD to active-low seven-segment decoder
module bcd_to_seg7
    import timer_display_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    // Non-decimal codes render as a dash so corrupt digit storage is visible
    always_comb begin
        if (i_bcd <= 4'd9) begin
            o_seg_n = SEG7_TABLE[i_bcd];
        end else begin
            o_seg_n = SEG7_DASH;
        end
    end

endmodule

// File: rtl/timer_display_scan.sv
// rtl/timer_display_scan.sv - frame-snapshot multiplexed seven-segment scan driver
module timer_display_scan
    import timer_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int BLINK_FRAMES = 64
) (
    input logic                clk,
    input logic                rst,
    timer_display_scan_if.slave bus
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int FRM_W   = $clog2(BLINK_FRAMES) + 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [FRM_W-1:0]        r_frame;
    logic                    r_phase;
    logic [4*NUM_DIGITS-1:0] r_snap_digits;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic                    r_snap_lz;
    logic [NUM_DIGITS-1:0]   r_snap_blink;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic                    r_frame_start;

    logic [3:0]              w_digit;
    logic [6:0]              w_dec;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_an_drive;
    logic                    w_last;

    assign w_digit = r_snap_digits[4*r_idx +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd   (w_digit),
        .o_seg_n (w_dec)
    );

    // A digit is a leading zero when it and everything above it is zero; digit 0 always shows
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (r_snap_digits[4*i +: 4] == 4'd0);
            w_lz[i]    = w_zero_run & r_snap_lz;
        end
    end

    assign w_seg      = w_lz[r_idx] ? SEG7_BLANK : w_dec;
    assign w_an_drive = (r_phase && r_snap_blink[r_idx]) ? '1
                      : ~(NUM_DIGITS'(1) << r_idx);
    assign w_last     = (r_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_frame       <= '0;
            r_phase       <= 1'b0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_snap_lz     <= 1'b0;
            r_snap_blink  <= '0;
            r_an_n        <= '1;
            r_seg_n       <= SEG7_BLANK;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_snap_digits <= bus.digits_in;
                    r_snap_dp     <= bus.dp_mask;
                    r_snap_lz     <= bus.blank_lz;
                    r_snap_blink  <= bus.blink_en;
                    r_frame_start <= 1'b1;
                    r_idx         <= '0;
                    r_cnt         <= '0;
                    r_state       <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRIVE;
                        r_an_n  <= w_an_drive;
                        r_seg_n <= w_seg;
                        r_dp_n  <= ~r_snap_dp[r_idx];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_BLANK;
                        r_an_n  <= '1;
                        r_seg_n <= SEG7_BLANK;
                        r_dp_n  <= 1'b1;
                        if (!w_last) begin
                            r_idx <= r_idx + IDX_W'(1);
                        end else begin
                            r_idx         <= '0;
                            r_snap_digits <= bus.digits_in;
                            r_snap_dp     <= bus.dp_mask;
                            r_snap_lz     <= bus.blank_lz;
                            r_snap_blink  <= bus.blink_en;
                            r_frame_start <= 1'b1;
                            if (r_frame == FRM_W'(BLINK_FRAMES - 1)) begin
                                r_frame <= '0;
                                r_phase <= ~r_phase;
                            end else begin
                                r_frame <= r_frame + FRM_W'(1);
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.an_n        = r_an_n;
    assign bus.seg_n       = r_seg_n;
    assign bus.dp_n        = r_dp_n;
    assign bus.frame_start = r_frame_start;

endmodule

// File: doc/timer_display_scan.md
# timer_display_scan

Multiplexed seven-segment display driver for the two-mode timer. It reads the timer's stored BCD digit registers once per scan frame into a snapshot, so a frame never shows a torn value. It then drives one common-anode digit at a time, with inter-digit blanking, leading-zero suppression and per-digit blinking for set mode. It sits between the timer's digit storage flops and the board's segment/anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 50000, clk cycles each digit is driven (≥1)
- BLANK_CYCLES, 8, clk cycles all anodes are off between digits (≥1)
- BLINK_FRAMES, 64, frames per blink half-period (≥1)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- digits_in  in  4*NUM_DIGITS  BCD digits, digit 0 = least significant in bits [3:0]
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit
- blank_lz  in  1  1 = suppress leading zeros
- blink_en  in  NUM_DIGITS  1 = digit blinks
- an_n  out  NUM_DIGITS  active-low anode enables
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
- dp_n  out  1  active-low decimal point
- frame_start  out  1  one-cycle pulse when a snapshot is taken

## Operation
- States: IDLE, BLANK, DRIVE. Registers: digit index (0..NUM_DIGITS-1), cycle counter, frame counter, blink phase, snapshot of digits_in/dp_mask/blank_lz/blink_en.
- IDLE is the reset state only. On the next edge: load the snapshot, pulse frame_start, go to BLANK with index 0.
- BLANK: an_n all 1, seg_n all 1, dp_n 1, for BLANK_CYCLES cycles. Then go to DRIVE for the same index.
- DRIVE: an_n[index]=0 for REFRESH_DIV cycles, then go to BLANK.
  - If index < NUM_DIGITS-1, increment the index.
  - Else wrap to index 0, load the snapshot, pulse frame_start, and increment the frame counter.
- All decode uses the snapshot only. digits_in changing mid-frame has no visible effect until the next frame.
- Decode:
  - 0-9 use standard patterns (0=7'b1000000, 1=7'b1111001, 8=7'b0000000).
  - Codes A-F show a dash (7'b0111111).
- Leading-zero suppression: with blank_lz=1, digit i is suppressed when it and every more significant snapshot digit equal 0. Digit 0 is never suppressed.
- Suppressed digit: the anode is still asserted, seg_n=7'h7F, and dp_n still follows dp_mask.
- Blink:
  - The frame counter wraps at BLINK_FRAMES-1, and the blink phase toggles on that wrap.
  - When phase=1, digits with blink_en set are driven with an_n all 1 for their DRIVE window. Timing is unchanged.
  - The phase starts at 0.
- Reset mid-operation: all outputs go inactive immediately (async), state=IDLE, counters 0, phase 0, snapshot 0.

## Timing
- Reset values:
  - an_n all 1, seg_n 7'h7F, dp_n 1, frame_start 0.
  - State IDLE, index 0, counters 0.
- All outputs are registered and change only on clk rising edges, except on async reset.
- Edge 1 after rst release: snapshot loaded, frame_start=1 for one cycle.
- an_n[0] falls on edge 1+BLANK_CYCLES and rises after REFRESH_DIV cycles.
- Digit period = BLANK_CYCLES+REFRESH_DIV. Frame = NUM_DIGITS × digit period.
- frame_start pulses every frame, on the same edge the snapshot loads.
- At most one an_n bit is low at any time. Every digit transition has at least BLANK_CYCLES all-off cycles.

## Structure
- A shared timer package holds the BCD-to-seven-segment constant table, the dash and blank patterns, and the state encoding.
- One sub-module: bcd_to_seg7, a combinational decoder for 4-bit BCD to 7-bit active-low. It is reusable by other timer displays.
- The scan FSM, counters and snapshot live in timer_display_scan.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset check: hold rst, toggle clk -> an_n=4'hF, seg_n=7'h7F, dp_n=1. Release rst -> frame_start on edge 1, an_n=4'hE on edges 2-5, 4'hF on edge 6, 4'hD on edges 7-10.
- Decode: digits_in=16'h1234, blank_lz=0 -> digit 0 shows 4 (7'b0011001), digit 3 shows 1 (7'b1111001). digits_in nibble A shows the dash.
- Leading zeros: digits_in=16'h0050, blank_lz=1 -> digits 3,2 give seg_n=7'h7F, digit 1 shows 5, digit 0 shows 0. digits_in=16'h0000 -> only digit 0 shows 0.
- Tearing: change digits_in mid-frame from 16'h1111 to 16'h2222 -> the rest of the frame shows 1s, the next frame shows 2s.
- Blink: blink_en=4'b0001 -> digit 0's anode is active in frames 0-1, held off in frames 2-3, active in frames 4-5.
- Async reset mid-DRIVE -> an_n=4'hF in the same timestep. After release, the sequence restarts from IDLE.
